// File: rtl/key_expansion_if.sv
// Round-key producer bus: start/key load on the request side, valid/ready
// handshake plus status on the response side.
interface key_expansion_if;
   logic         start;
   logic [127:0] cipherKey;
   logic         rkReady;
   logic         rkValid;
   logic [127:0] roundKey;
   logic [3:0]   rkRound;
   logic         busy;
   logic         done;

   modport slave (
      input  start, cipherKey, rkReady,
      output rkValid, roundKey, rkRound, busy, done
   );

   modport master (
      output start, cipherKey, rkReady,
      input  rkValid, roundKey, rkRound, busy, done
   );
endinterface

// File: rtl/key_expansion_seq.sv
// Iterative AES-128 key schedule: emits round keys 0..NUM_ROUNDS, one per
// accepted valid/ready beat, computing the next key with a single SubWord.

module sbox_byte (
   input  logic [7:0] din,
   output logic [7:0] dout
);
   // Entry 0 sits in the top byte, so the index is mirrored below.
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign dout = SBOX_TBL[8*(255 - int'(din)) +: 8];
endmodule

module key_expansion_seq #(
   parameter int NUM_ROUNDS = 10
) (
   input  logic             clk,
   input  logic             reset,
   key_expansion_if.slave   kx
);
   localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t       state_q, state_d;
   logic [127:0] key_q, key_d;
   logic [3:0]   round_q, round_d;
   logic         done_q, done_d;

   logic [31:0]  w0, w1, w2, w3;
   logic [31:0]  rot_w, sub_w, t_w;
   logic [31:0]  n0, n1, n2, n3;
   logic [3:0]   nxt_round;
   logic [7:0]   rcon;

   assign {w0, w1, w2, w3} = key_q;
   assign rot_w = {w3[23:0], w3[31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_sub
      sbox_byte u_sbox (.din(rot_w[8*i +: 8]), .dout(sub_w[8*i +: 8]));
   end

   assign nxt_round = round_q + 4'd1;

   always_comb begin
      rcon = 8'h00;
      case (nxt_round)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   end

   assign t_w = sub_w ^ {rcon, 24'h0};
   assign n0  = w0 ^ t_w;
   assign n1  = w1 ^ n0;
   assign n2  = w2 ^ n1;
   assign n3  = w3 ^ n2;

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      round_d = round_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (kx.start) begin
               key_d   = kx.cipherKey;
               round_d = 4'd0;
               state_d = EMIT;
            end
         end
         EMIT: begin
            // Without a beat everything holds, so a stalled key is never lost.
            if (kx.rkReady) begin
               if (round_q == LAST_ROUND) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  key_d   = {n0, n1, n2, n3};
                  round_d = nxt_round;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         key_q   <= '0;
         round_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         round_q <= round_d;
         done_q  <= done_d;
      end
   end

   assign kx.rkValid  = (state_q == EMIT);
   assign kx.busy     = (state_q == EMIT);
   assign kx.roundKey = key_q;
   assign kx.rkRound  = round_q;
   assign kx.done     = done_q;
endmodule

// File: tb/tb_key_expansion_seq.sv
// Scoreboard bench for key_expansion_seq: directed FIPS-197 / zero-key
// schedules, backpressure, start glitches, mid-run reset and back-to-back start.
module tb_key_expansion_seq;
   localparam int NR = 10;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   key_expansion_if kx();

   key_expansion_seq #(.NUM_ROUNDS(NR)) dut (
      .clk   (clk),
      .reset (reset),
      .kx    (kx)
   );

   typedef struct {
      logic [3:0]   rnd;
      logic [127:0] key;
      bit           chk_key;
   } exp_t;

   exp_t sb_q[$];

   logic [127:0] fips_rk [11] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f,
      128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00,
      128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd,
      128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f,
      128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6
   };
   logic [127:0] zero_rk1  = 128'h62636363626363636263636362636363;
   logic [127:0] zero_rk10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [3:0] rnd, input logic [127:0] key, input bit ck);
      exp_t e;
      e.rnd = rnd; e.key = key; e.chk_key = ck;
      sb_q.push_back(e);
   endtask

   task automatic monitor_loop();
      logic pv, pr;
      logic [127:0] pk;
      logic [3:0] prd;
      exp_t e;
      pv = 1'b0; pr = 1'b0; pk = '0; prd = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            pv = 1'b0;
         end else begin
            if (kx.rkValid && pv && !pr) begin
               chk("hold_key", kx.roundKey, pk);
               chk("hold_round", 128'(kx.rkRound), 128'(prd));
            end
            if (kx.rkValid && kx.rkReady) begin
               if (sb_q.size() == 0) begin
                  n_vec++; n_err++;
                  $display("FAIL unexpected_beat: got round %0d want none", kx.rkRound);
               end else begin
                  e = sb_q.pop_front();
                  chk("beat_round", 128'(kx.rkRound), 128'(e.rnd));
                  if (e.chk_key) chk("beat_key", kx.roundKey, e.key);
               end
            end
            pv = kx.rkValid; pr = kx.rkReady; pk = kx.roundKey; prd = kx.rkRound;
         end
      end
   endtask

   task automatic start_key(input logic [127:0] k);
      kx.start = 1'b1; kx.cipherKey = k;
      @(posedge clk); #1;
      kx.start = 1'b0;
   endtask

   // Returns at posedge+1 of the cycle where done is high.
   task automatic wait_done(input bit random_drive, output int cyc);
      cyc = 0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         cyc++;
         if (kx.done) begin
            kx.start = 1'b0;
            return;
         end
         if (random_drive) begin
            kx.rkReady   = 1'($urandom_range(0, 1));
            kx.start     = 1'($urandom_range(0, 1));
            kx.cipherKey = {$urandom, $urandom, $urandom, $urandom};
         end
      end
      n_vec++; n_err++;
      $display("FAIL done_timeout: got no done want done within 400 cycles");
      cyc = -1;
   endtask

   initial begin
      int cyc;
      reset = 1'b1;
      kx.start = 1'b0; kx.cipherKey = '0; kx.rkReady = 1'b0;
      fork monitor_loop(); join_none

      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 128'(kx.rkValid), 128'(0));
      chk("rst_key",   kx.roundKey, 128'(0));
      chk("rst_round", 128'(kx.rkRound), 128'(0));
      chk("rst_busy",  128'(kx.busy), 128'(0));
      chk("rst_done",  128'(kx.done), 128'(0));
      // start while in reset must be overridden
      kx.start = 1'b1; kx.cipherKey = fips_rk[0];
      @(posedge clk); #1;
      chk("rst_over_start", 128'(kx.rkValid), 128'(0));
      kx.start = 1'b0;
      reset = 1'b0;
      @(posedge clk); #1;

      // FIPS key, always ready
      for (int r = 0; r <= NR; r++) push(4'(r), fips_rk[r], 1'b1);
      kx.rkReady = 1'b1;
      start_key(fips_rk[0]);
      chk("first_valid", 128'(kx.rkValid), 128'(1));
      chk("first_busy",  128'(kx.busy), 128'(1));
      wait_done(1'b0, cyc);
      chk("done_latency", 128'(cyc), 128'(11));
      chk("done_valid_low", 128'(kx.rkValid), 128'(0));
      chk("idle_round_hold", 128'(kx.rkRound), 128'(NR));
      chk("idle_key_hold", kx.roundKey, fips_rk[NR]);

      // back-to-back start in the done cycle, then backpressure + start glitches
      for (int r = 0; r <= NR; r++) push(4'(r), fips_rk[r], 1'b1);
      start_key(fips_rk[0]);
      chk("b2b_valid", 128'(kx.rkValid), 128'(1));
      chk("b2b_key",   kx.roundKey, fips_rk[0]);
      chk("b2b_round", 128'(kx.rkRound), 128'(0));
      wait_done(1'b1, cyc);
      @(posedge clk); #1;
      chk("done_pulse_width", 128'(kx.done), 128'(0));

      // reset after rk4 is accepted
      for (int r = 0; r <= 4; r++) push(4'(r), fips_rk[r], 1'b1);
      kx.rkReady = 1'b1;
      start_key(fips_rk[0]);
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b1; kx.rkReady = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("midrst_valid", 128'(kx.rkValid), 128'(0));
      chk("midrst_busy",  128'(kx.busy), 128'(0));
      chk("midrst_round", 128'(kx.rkRound), 128'(0));

      // zero key restarts from round 0
      push(4'd0, 128'(0), 1'b1);
      push(4'd1, zero_rk1, 1'b1);
      for (int r = 2; r < NR; r++) push(4'(r), 128'(0), 1'b0);
      push(4'(NR), zero_rk10, 1'b1);
      kx.rkReady = 1'b1;
      start_key(128'(0));
      wait_done(1'b0, cyc);
      chk("zero_done_latency", 128'(cyc), 128'(11));

      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", 128'(sb_q.size()), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
